jtoutrun_adc: RTL and testbench
===============================

JTOUTRUN_ADC -- requirements
Module: jtoutrun_adc

Interface
REQ-001 SHALL have parameter CONV_TICKS, default 64: cen ticks from conversion start to end-of-conversion.
REQ-002 SHALL have parameter RAMP_TICKS, default 256: cen ticks per 1-LSB step of the keyboard steering ramp.
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 rstn  in  1  reset, asynchronous and active-low.
REQ-005 cen  in  1  CPU clock enable; counters advance only when cen=1.
REQ-006 cs  in  1  ADC select (I/O region, A[6:4]==3), one clk per bus access.
REQ-007 rnw  in  1  1=read access, 0=write access (write = start conversion).
REQ-008 ch  in  3  channel select from PPI port C [4:2].
REQ-009 joystick1  in  8  active-low digital controls; bit0 left, bit1 right, bit2 brake, bit3 gas.
REQ-010 joyana1  in  16  steering; [7:0] signed, centre 0.
REQ-011 joyana1b  in  16  pedals; [15] sign, [14:8] magnitude.
REQ-012 dout  out  8  last conversion result.
REQ-013 busy  out  1  high while a conversion is in progress.
REQ-014 eoc  out  1  one-clk pulse when a conversion completes.

Function
REQ-015 Input mapping SHALL be: ch0 = ramp value if bit0 or bit1 is low, else joyana1[7:0]^8'h80; ch1 = 8'hF0 if bit3 low, else ~{joyana1b[14:8],joyana1b[14]} when joyana1b[15]=1, else 8'h00; ch2 = 8'hF0 if bit2 low, else {joyana1b[14:8],joyana1b[14]} when joyana1b[15]=0, else 8'h00; ch3-7 = 8'hFF.
REQ-016 FSM SHALL have states IDLE and CONV.
REQ-017 In IDLE, cs=1 with rnw=0 SHALL sample the mapped value of ch into a hold register, clear the tick counter, and enter CONV on the next clk.
REQ-018 In CONV, the tick counter SHALL increment on each cen; when it reaches CONV_TICKS-1 with cen=1, dout SHALL load the hold register, eoc SHALL pulse for 1 clk, and the FSM SHALL return to IDLE.
REQ-019 busy SHALL equal (state==CONV).
REQ-020 A write during CONV SHALL restart conversion: resample with the current ch, clear the counter, stay in CONV, emit no eoc.
REQ-021 A read (cs=1, rnw=1) SHALL NOT change state; dout SHALL hold the previous result during CONV.
REQ-022 A write and the completing tick in the same clk: the write SHALL win; no eoc, restart per REQ-020.
REQ-023 Ramp register: when bit0 is low and bit1 is high, step +1 every RAMP_TICKS cen ticks toward 8'hD0, saturating.
REQ-024 Ramp register: when bit1 is low and bit0 is high, step -1 toward 8'h20, saturating.
REQ-025 Ramp register: when both bits are low, hold its value.
REQ-026 Ramp register: when both bits are high, load 8'h80 immediately and clear the ramp counter.
REQ-027 Changes to ch or inputs during CONV SHALL NOT affect the converted value (sample-and-hold).

Reset
REQ-028 rstn=0 SHALL asynchronously force state=IDLE, dout=8'hFF, busy=0, eoc=0, hold=8'hFF, ramp=8'h80, all counters 0.
REQ-029 Release of rstn mid-conversion SHALL leave the block in IDLE with dout=8'hFF until the next completed conversion.

Verification
REQ-030 cen every clk, ch=0, joyana1[7:0]=8'h10, write -> busy for 64 cen; eoc pulse once; dout=8'h90.
REQ-031 ch=1, joystick1[3]=0, write; flip bit3 high mid-CONV -> dout=8'hF0 (held sample).
REQ-032 Write; second write at tick 30 with ch=2, joyana1b=16'h0000 -> single eoc 64 ticks after the second write; dout=8'h00.
REQ-033 RAMP_TICKS=4, hold bit0 low 1000 cen -> ramp saturates at 8'hD0; release -> 8'h80 the next clk.
REQ-034 ch=5, write, complete -> dout=8'hFF; rstn low at tick 20 of a later conversion -> busy=0, no eoc, dout=8'hFF.

Source files
------------

// File: rtl/jtoutrun_adc.sv
// Out Run analogue input ADC: channel multiplexer, keyboard steering ramp and a
// sample-and-hold converter that reports its result after CONV_TICKS cen ticks.
module jtoutrun_adc #(
    parameter int CONV_TICKS = 64,
    parameter int RAMP_TICKS = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cen,
    input  logic        cs,
    input  logic        rnw,
    input  logic [2:0]  ch,
    input  logic [7:0]  joystick1,
    input  logic [15:0] joyana1,
    input  logic [15:0] joyana1b,
    output logic [7:0]  dout,
    output logic        busy,
    output logic        eoc
);

    localparam int CW = (CONV_TICKS > 1) ? $clog2(CONV_TICKS) : 1;
    localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_TICKS - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_TICKS - 1);
    localparam logic [7:0] RAMP_MAX    = 8'hD0;
    localparam logic [7:0] RAMP_MIN    = 8'h20;
    localparam logic [7:0] RAMP_CENTRE = 8'h80;

    typedef enum logic {IDLE, CONV} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] tick_cnt, tick_nx;
    logic [7:0]    hold, hold_nx;
    logic [7:0]    dout_nx;
    logic          eoc_nx;
    logic [7:0]    ramp;
    logic [RW-1:0] ramp_cnt;
    logic [7:0]    mapped;
    logic          write;

    assign write = cs & ~rnw;
    assign busy  = (state == CONV);

    // Steering keys override the analogue wheel; pedal keys give a fixed 0xF0.
    always_comb begin
        mapped = 8'hFF;
        unique case (ch)
            3'd0: mapped = (!joystick1[0] || !joystick1[1]) ? ramp : (joyana1[7:0] ^ 8'h80);
            3'd1: mapped = !joystick1[3] ? 8'hF0 :
                           joyana1b[15] ? ~{joyana1b[14:8], joyana1b[14]} : 8'h00;
            3'd2: mapped = !joystick1[2] ? 8'hF0 :
                           !joyana1b[15] ? {joyana1b[14:8], joyana1b[14]} : 8'h00;
            default: mapped = 8'hFF;
        endcase
    end

    // NOTE: every output gets its default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx = state;
        tick_nx  = tick_cnt;
        hold_nx  = hold;
        dout_nx  = dout;
        eoc_nx   = 1'b0;
        if (write) begin
            // A write always (re)starts, even on the tick that would have completed.
            hold_nx  = mapped;
            tick_nx  = '0;
            state_nx = CONV;
        end else if (state == CONV && cen) begin
            if (tick_cnt == CONV_LAST) begin
                dout_nx  = hold;
                eoc_nx   = 1'b1;
                tick_nx  = '0;
                state_nx = IDLE;
            end else begin
                tick_nx = tick_cnt + CW'(1);
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tick_cnt <= '0;
            hold     <= 8'hFF;
            dout     <= 8'hFF;
            eoc      <= 1'b0;
        end else begin
            state    <= state_nx;
            tick_cnt <= tick_nx;
            hold     <= hold_nx;
            dout     <= dout_nx;
            eoc      <= eoc_nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ramp     <= RAMP_CENTRE;
            ramp_cnt <= '0;
        end else begin
            unique case (joystick1[1:0])
                2'b11: begin
                    ramp     <= RAMP_CENTRE;
                    ramp_cnt <= '0;
                end
                2'b00: ;
                default: if (cen) begin
                    if (ramp_cnt == RAMP_LAST) begin
                        ramp_cnt <= '0;
                        if (!joystick1[0]) begin
                            if (ramp < RAMP_MAX) ramp <= ramp + 8'd1;
                        end else begin
                            if (ramp > RAMP_MIN) ramp <= ramp - 8'd1;
                        end
                    end else begin
                        ramp_cnt <= ramp_cnt + RW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtoutrun_adc.sv
// Scoreboard bench for jtoutrun_adc: a behavioural model predicts each
// conversion result and a negedge monitor checks the DUT against it.
module tb_jtoutrun_adc;

    localparam int CONV = 64;
    localparam int RT   = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cen, cs, rnw;
    logic [2:0]  ch;
    logic [7:0]  joystick1;
    logic [15:0] joyana1, joyana1b;
    logic [7:0]  dout;
    logic        busy, eoc;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       m_busy, m_eoc;
    logic [7:0] m_dout, m_hold, m_ramp;
    int         m_left, m_rdiv;

    jtoutrun_adc #(.CONV_TICKS(CONV), .RAMP_TICKS(RT)) dut (
        .clk(clk), .rstn(rstn), .cen(cen), .cs(cs), .rnw(rnw), .ch(ch),
        .joystick1(joystick1), .joyana1(joyana1), .joyana1b(joyana1b),
        .dout(dout), .busy(busy), .eoc(eoc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] map_ch(input logic [2:0] c, input logic [7:0] js,
                                         input logic [15:0] a1, input logic [15:0] a1b,
                                         input logic [7:0] r);
        logic [6:0] mag;
        mag = a1b[14:8];
        case (c)
            3'd0: return (js[0] && js[1]) ? (a1[7:0] ^ 8'h80) : r;
            3'd1: if (!js[3]) return 8'hF0; else if (a1b[15]) return ~{mag, mag[6]}; else return 8'h00;
            3'd2: if (!js[2]) return 8'hF0; else if (!a1b[15]) return {mag, mag[6]}; else return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_eoc = 1'b0; m_dout = 8'hFF; m_hold = 8'hFF;
        m_ramp = 8'h80; m_left = 0; m_rdiv = 0;
        exp_q.delete();
    endtask

    // One clock of behaviour, using the inputs as they stand at the rising edge.
    task automatic model_step();
        logic [7:0] mv;
        m_eoc = 1'b0;
        mv = map_ch(ch, joystick1, joyana1, joyana1b, m_ramp);
        if (cs && !rnw) begin
            m_hold = mv; m_left = CONV; m_busy = 1'b1;
        end else if (m_busy && cen) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_dout = m_hold; m_eoc = 1'b1;
                exp_q.push_back(m_hold);
            end
        end
        if (joystick1[1:0] == 2'b11) begin
            m_ramp = 8'h80; m_rdiv = 0;
        end else if (joystick1[1:0] != 2'b00 && cen) begin
            m_rdiv++;
            if (m_rdiv == RT) begin
                m_rdiv = 0;
                if (!joystick1[0]) m_ramp = (m_ramp >= 8'hD0) ? m_ramp : m_ramp + 8'd1;
                else               m_ramp = (m_ramp <= 8'h20) ? m_ramp : m_ramp - 8'd1;
            end
        end
    endtask

    always @(negedge clk) begin
        check("busy", {15'd0, busy}, {15'd0, m_busy});
        check("eoc", {15'd0, eoc}, {15'd0, m_eoc});
        check("dout", {8'd0, dout}, {8'd0, m_dout});
        if (eoc === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("eoc_unexpected", 16'd1, 16'd0);
            end else begin
                check("eoc_result", {8'd0, dout}, {8'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            if (rstn) model_step();
            @(negedge clk);
        end
    endtask

    task automatic write_ch(input logic [2:0] c);
        ch = c; cs = 1'b1; rnw = 1'b0;
        tick();
        cs = 1'b0; rnw = 1'b1;
    endtask

    task automatic pulse_reset();
        #2;
        rstn = 1'b0;
        model_reset();
        tick(3);
        #2;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; cen = 1'b1; cs = 1'b0; rnw = 1'b1; ch = 3'd0;
        joystick1 = 8'hFF; joyana1 = 16'h0010; joyana1b = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);

        // Wheel centre offset: 0x10 ^ 0x80.
        write_ch(3'd0);
        tick(CONV + 4);

        // Gas key held at sample time, released mid-conversion.
        joystick1 = 8'hF7;
        write_ch(3'd1);
        tick(10);
        joystick1 = 8'hFF;
        tick(CONV);

        // Restart after 30 ticks on a different channel.
        joyana1b = 16'h7F00;
        write_ch(3'd0);
        tick(29);
        joyana1b = 16'h0000;
        write_ch(3'd2);
        tick(CONV + 4);

        // A write on the exact completing tick must win.
        write_ch(3'd1);
        tick(CONV - 1);
        joyana1b = 16'h8500;
        write_ch(3'd1);
        tick(CONV + 4);

        // Ramp saturation in both directions, then recentring.
        joystick1 = 8'hFE;
        tick(1000);
        write_ch(3'd0);
        tick(CONV + 4);
        joystick1 = 8'hFD;
        tick(1000);
        write_ch(3'd0);
        tick(CONV + 4);
        joystick1 = 8'hFF;
        tick();
        joystick1 = 8'hFC;
        write_ch(3'd0);
        tick(CONV + 4);
        joystick1 = 8'hFF;

        // Unused channel, then a reset that aborts a conversion.
        write_ch(3'd5);
        tick(CONV + 4);
        joyana1 = 16'h0033;
        write_ch(3'd0);
        tick(20);
        pulse_reset();
        tick(CONV + 4);

        // Randomised traffic with gated cen and read accesses.
        for (int i = 0; i < 4000; i++) begin
            cen = ($urandom_range(3) != 0);
            joyana1 = 16'($urandom);
            joyana1b = 16'($urandom);
            if (i % 60 == 0) joystick1 = {4'hF, 4'($urandom)};
            ch = 3'($urandom);
            if ($urandom_range(119) == 0) begin
                cs = 1'b1; rnw = 1'b0;
            end else begin
                cs = ($urandom_range(7) == 0); rnw = 1'b1;
            end
            tick();
        end
        cs = 1'b0; rnw = 1'b1; cen = 1'b1;
        tick(CONV + 4);

        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
